// File: rtl/magma_entry_driver.sv
// Magma front-panel driver: debounced nibble entry, paged 7-seg view, core launch.
// Optional: ENTRY_AUTOREPEAT_EN enables held left/right autorepeat in edit modes.
module magma_entry_driver #(
   parameter int DATA_W    = 128,
   parameter int DIGITS    = 8,
   parameter int DB_CYCLES = 50000,
   parameter int BLINK_W   = 24,
   parameter int AR_DELAY  = 25000000,
   parameter int AR_PERIOD = 5000000,
   localparam int PAGES    = DATA_W / (4 * DIGITS),
   localparam int PW       = (PAGES > 1) ? $clog2(PAGES) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            btn,
   input  logic [2:0]            mode,
   input  logic [PW-1:0]         page,
   input  logic [3:0]            nibble,
   output logic [PAGES-1:0]      page_led,
   output logic [2:0]            mode_led,
   output logic [7*DIGITS-1:0]   seg,
   output logic [DATA_W-1:0]     data_o,
   output logic [DATA_W-1:0]     key_o,
   output logic                  req_valid,
   input  logic                  req_ready,
   input  logic                  res_valid,
   input  logic [DATA_W-1:0]     res_data,
   output logic                  busy
);

   localparam int NIBS = DATA_W / 4;
   localparam int NW   = (NIBS > 1) ? $clog2(NIBS) : 1;
   localparam int CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int DBW  = $clog2(DB_CYCLES + 1);

   if ((DATA_W % (4 * DIGITS)) != 0 || DB_CYCLES < 1 || BLINK_W < 1) begin : g_cfg_chk
      $error("DATA_W must be a multiple of 4*DIGITS; counters must be positive");
   end
   if (AR_DELAY < 1 || AR_PERIOD < 1) begin : g_ar_chk
      $error("AR_DELAY and AR_PERIOD must be positive");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_e;

   logic [2:0]           sync1_q, sync2_q;
   logic [2:0]           db_q, dbp_q;
   logic [DBW-1:0]       cnt_q [3];
   logic [2:0]           ev;
   logic                 mv_l, mv_r, st_ev;
   logic                 ar_l, ar_r;
   logic                 m_data, m_key, m_res, m_idle, edit;
   logic                 pg_ok;
   logic [CW-1:0]        cur_q;
   logic [DATA_W-1:0]    data_q, key_q, res_q;
   logic [BLINK_W-1:0]   blk_q;
   state_e               st_q;
   logic                 req_valid_q, busy_q;
   logic [NW-1:0]        wi;
   logic [DATA_W-1:0]    src;
   logic [NW-1:0]        di;
   logic [3:0]           dv;
   logic                 hit;

   always_comb begin
      m_data = 1'b0;
      m_key  = 1'b0;
      m_res  = 1'b0;
      m_idle = 1'b0;
      priority case (1'b1)
         mode[0]: m_data = 1'b1;
         mode[1]: m_key  = 1'b1;
         mode[2]: m_res  = 1'b1;
         default: m_idle = 1'b1;
      endcase
   end

   assign edit     = m_data | m_key;
   assign mode_led = {m_res, m_key, m_idle | m_data};
   assign pg_ok    = ({1'b0, page} < (PW + 1)'(PAGES));

   // Synchroniser plus per-button stability counter; levels idle released (1).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
         db_q    <= '1;
         dbp_q   <= '1;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         dbp_q   <= db_q;
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == db_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == DBW'(DB_CYCLES - 1)) begin
               cnt_q[i] <= '0;
               db_q[i]  <= sync2_q[i];
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign ev = dbp_q & ~db_q;

`ifdef ENTRY_AUTOREPEAT_EN
   localparam int ARM = (AR_DELAY > AR_PERIOD) ? AR_DELAY : AR_PERIOD;
   localparam int ARW = $clog2(ARM + 1);

   logic [ARW-1:0] ar_cnt_q;
   logic           ar_arm_q, ar_dir_q, ar_l_q, ar_r_q;
   logic           hold_l, hold_r;

   assign hold_l = edit & (db_q == 3'b110);
   assign hold_r = edit & (db_q == 3'b101);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ar_cnt_q <= '0;
         ar_arm_q <= 1'b0;
         ar_dir_q <= 1'b0;
         ar_l_q   <= 1'b0;
         ar_r_q   <= 1'b0;
      end else begin
         ar_l_q <= 1'b0;
         ar_r_q <= 1'b0;
         if (!(hold_l | hold_r) || (ar_dir_q != hold_r)) begin
            ar_cnt_q <= '0;
            ar_arm_q <= 1'b0;
            ar_dir_q <= hold_r;
         end else if (ar_cnt_q == (ar_arm_q ? ARW'(AR_PERIOD - 1)
                                            : ARW'(AR_DELAY - 1))) begin
            ar_cnt_q <= '0;
            ar_arm_q <= 1'b1;
            ar_l_q   <= hold_l;
            ar_r_q   <= hold_r;
         end else begin
            ar_cnt_q <= ar_cnt_q + 1'b1;
         end
      end
   end

   assign ar_l = ar_l_q;
   assign ar_r = ar_r_q;
`else
   assign ar_l = 1'b0;
   assign ar_r = 1'b0;
`endif

   // Simultaneous press events cancel each other.
   assign mv_l  = (ev == 3'b001) | ar_l;
   assign mv_r  = (ev == 3'b010) | ar_r;
   assign st_ev = (ev == 3'b100);

   assign wi = NW'(page) * NW'(DIGITS) + NW'(cur_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_q  <= '0;
         data_q <= '0;
         key_q  <= '0;
      end else begin
         if (edit && mv_l)
            cur_q <= (cur_q == CW'(DIGITS - 1)) ? '0 : cur_q + 1'b1;
         else if (edit && mv_r)
            cur_q <= (cur_q == '0) ? CW'(DIGITS - 1) : cur_q - 1'b1;
         if (st_ev && !busy_q && pg_ok) begin
            if (m_data) data_q[{wi, 2'b00} +: 4] <= nibble;
            if (m_key)  key_q[{wi, 2'b00} +: 4]  <= nibble;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) blk_q <= '0;
      else        blk_q <= blk_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q        <= S_IDLE;
         req_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         res_q       <= '0;
      end else begin
         unique case (st_q)
            S_IDLE: if (st_ev && m_idle) begin
               st_q        <= S_REQ;
               req_valid_q <= 1'b1;
               busy_q      <= 1'b1;
            end
            S_REQ: if (req_ready) begin
               st_q        <= S_WAIT;
               req_valid_q <= 1'b0;
            end
            S_WAIT: if (res_valid) begin
               res_q  <= res_data;
               st_q   <= S_IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               st_q        <= S_IDLE;
               req_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign req_valid = req_valid_q;
   assign busy      = busy_q;
   assign data_o    = data_q;
   assign key_o     = key_q;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      hex7 = 7'b1111111;
      unique case (v)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         4'hF: hex7 = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      src = data_q;
      priority case (1'b1)
         m_key:   src = key_q;
         m_res:   src = res_q;
         default: src = data_q;
      endcase
   end

   // Edit modes preview the pending nibble at the cursor and blink it.
   always_comb begin
      seg = '1;
      di  = '0;
      dv  = '0;
      hit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         di  = NW'(page) * NW'(DIGITS) + NW'(i);
         hit = edit && (CW'(i) == cur_q);
         dv  = hit ? nibble : src[{di, 2'b00} +: 4];
         if (pg_ok && !(hit && !blk_q[BLINK_W-1]))
            seg[7*i +: 7] = hex7(dv);
      end
   end

   always_comb begin
      page_led = '0;
      for (int p = 0; p < PAGES; p++)
         page_led[p] = pg_ok && (page == PW'(p));
   end

endmodule

// File: tb/tb_magma_entry_driver.sv
// Scoreboard bench for magma_entry_driver: randomized panel
// operations checked against a behavioural model of the panel.
module tb_magma_entry_driver;

   localparam int DW = 128;
   localparam int DG = 8;
   localparam int DB = 4;
   localparam int BW = 4;
   localparam int HOLD = DB + 6;

   localparam logic [6:0] FONT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic            clk = 1'b0;
   logic            reset;
   logic [2:0]      btn, mode;
   logic [1:0]      page;
   logic [3:0]      nibble;
   logic [3:0]      page_led;
   logic [2:0]      mode_led;
   logic [7*DG-1:0] seg;
   logic [DW-1:0]   data_o, key_o, res_data;
   logic            req_valid, req_ready, res_valid, busy;

   magma_entry_driver #(
      .DATA_W(DW), .DIGITS(DG), .DB_CYCLES(DB), .BLINK_W(BW)
   ) dut (
      .clk(clk), .reset(reset), .btn(btn), .mode(mode),
      .page(page), .nibble(nibble), .page_led(page_led),
      .mode_led(mode_led), .seg(seg), .data_o(data_o),
      .key_o(key_o), .req_valid(req_valid),
      .req_ready(req_ready), .res_valid(res_valid),
      .res_data(res_data), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         nm;
      logic [DW-1:0] d, k, r;
      int            cur;
      logic [2:0]    md;
      int            pg;
      logic [3:0]    nb;
      int            st;
      int            run;
   } snap_t;

   snap_t sq[$];
   logic  snap = 1'b0;
   int    nchk = 0, npass = 0;
   int    rv_run = 0, last_run = 0;
   logic [3:0] cyc;

   // model state: st 0=idle, 1=request pending, 2=awaiting result
   logic [DW-1:0] m_data, m_key, m_res;
   int            m_cur, m_st;

   always @(posedge clk or negedge reset)
      if (!reset) cyc <= '0;
      else        cyc <= cyc + 1'b1;

   task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s: actual %h required %h", nm, act, exp);
   endtask

   function automatic logic [7*DG-1:0] exp_seg(snap_t s, logic [3:0] bc);
      logic [DW-1:0]   src;
      logic [3:0]      v;
      logic [7*DG-1:0] r;
      bit              ed;
      ed  = s.md[0] | s.md[1];
      src = s.md[0] ? s.d : s.md[1] ? s.k : s.md[2] ? s.r : s.d;
      for (int i = 0; i < DG; i++) begin
         v = src[4*(s.pg*DG+i) +: 4];
         if (ed && i == s.cur) v = s.nb;
         r[7*i +: 7] = (ed && i == s.cur && !bc[BW-1]) ? 7'h7F : FONT[v];
      end
      return r;
   endfunction

   always @(negedge clk) begin
      snap_t s;
      if (!reset) begin
         rv_run = 0;
         last_run = 0;
      end else if (req_valid) begin
         rv_run++;
      end else if (rv_run != 0) begin
         last_run = rv_run;
         rv_run = 0;
      end
      if (snap) begin
         chk("sb_queue", DW'(sq.size() != 0), 1);
         if (sq.size() != 0) begin
            s = sq.pop_front();
            chk({s.nm, "/data"}, data_o, s.d);
            chk({s.nm, "/key"}, key_o, s.k);
            chk({s.nm, "/busy"}, DW'(busy), DW'(s.st != 0));
            chk({s.nm, "/req_valid"}, DW'(req_valid), DW'(s.st == 1));
            chk({s.nm, "/seg"}, DW'(seg), DW'(exp_seg(s, cyc)));
            chk({s.nm, "/page_led"}, DW'(page_led), DW'(4'b1 << s.pg));
            if (s.run >= 0)
               chk({s.nm, "/rv_cycles"}, DW'(last_run), DW'(s.run));
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      m_data = '0;
      m_key  = '0;
      m_res  = '0;
      m_cur  = 0;
      m_st   = 0;
   endtask

   task automatic model_btn(logic [2:0] m);
      bit ed;
      ed = mode[0] | mode[1];
      if (m == 3'b001) begin
         if (ed) m_cur = (m_cur + 1) % DG;
      end else if (m == 3'b010) begin
         if (ed) m_cur = (m_cur + DG - 1) % DG;
      end else if (m == 3'b100) begin
         if (ed) begin
            if (m_st == 0) begin
               if (mode[0]) m_data[4*(int'(page)*DG+m_cur) +: 4] = nibble;
               else         m_key[4*(int'(page)*DG+m_cur) +: 4]  = nibble;
            end
         end else if (mode == 3'b000 && m_st == 0) begin
            m_st = 1;
         end
      end
   endtask

   task automatic press(logic [2:0] m);
      btn = ~m;
      repeat (HOLD) tick;
      btn = 3'b111;
      repeat (HOLD) tick;
      model_btn(m);
   endtask

   task automatic grant;
      req_ready = 1'b1;
      tick;
      req_ready = 1'b0;
      if (m_st == 1) m_st = 2;
   endtask

   task automatic respond(logic [DW-1:0] v);
      res_data  = v;
      res_valid = 1'b1;
      tick;
      res_valid = 1'b0;
      if (m_st == 2) begin
         m_res = v;
         m_st  = 0;
      end
   endtask

   task automatic snapshot(string nm, int run = -1);
      snap_t s;
      s.nm  = nm;
      s.d   = m_data;
      s.k   = m_key;
      s.r   = m_res;
      s.cur = m_cur;
      s.md  = mode;
      s.pg  = int'(page);
      s.nb  = nibble;
      s.st  = m_st;
      s.run = run;
      sq.push_back(s);
      snap = 1'b1;
      tick;
      snap = 1'b0;
   endtask

   function automatic logic [DW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      int op;
      reset = 1'b0; btn = 3'b111; mode = 3'b000; page = 2'd0;
      nibble = 4'h0; req_ready = 1'b0; res_valid = 1'b0; res_data = '0;
      model_reset();
      repeat (3) tick;
      snapshot("reset");
      reset = 1'b1;
      tick;

      mode = 3'b001; page = 2'd1; nibble = 4'hA;
      press(3'b010);
      press(3'b100);
      snapshot("data_wr");

      mode = 3'b000;
      press(3'b100);
      snapshot("req_pending");
      reset = 1'b0;
      model_reset();
      snapshot("reset_mid");
      reset = 1'b1;
      tick;
      respond(rnd128());
      snapshot("late_res");

      mode = 3'b010; page = 2'd3;
      repeat (9) press(3'b001);
      nibble = 4'h5;
      press(3'b100);
      snapshot("key_wr");

      mode = 3'b001; page = 2'd0; nibble = 4'h3;
      for (int k = 0; k < 10; k++) begin
         btn[2] = (k % 2 == 0) ? 1'b0 : 1'b1;
         tick;
         tick;
      end
      press(3'b100);
      snapshot("bounce");

      press(3'b011);
      snapshot("both_lr");

      mode = 3'b000;
      press(3'b100);
      mode = 3'b001; page = 2'd2; nibble = 4'hF;
      press(3'b100);
      snapshot("busy_set");
      respond(rnd128());
      snapshot("res_in_req");
      grant();
      respond(rnd128());
      snapshot("first_res");

      mode = 3'b000;
      btn = 3'b011;
      n = 0;
      while (!req_valid && n < 40) begin
         tick;
         n++;
      end
      chk("rv_rise", DW'(req_valid), 1);
      repeat (10) tick;
      req_ready = 1'b1;
      tick;
      req_ready = 1'b0;
      btn = 3'b111;
      repeat (HOLD) tick;
      model_btn(3'b100);
      if (m_st == 1) m_st = 2;
      snapshot("handshake", 11);
      respond(128'h0123456789ABCDEF0123456789ABCDEF);
      mode = 3'b100; page = 2'd0;
      snapshot("result");

      for (int i = 0; i < 40; i++) begin
         mode = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) mode = 3'b000;
         page = 2'($urandom_range(0, 3));
         nibble = 4'($urandom);
         op = $urandom_range(0, 6);
         case (op)
            0: press(3'b001);
            1: press(3'b010);
            2, 3: press(3'b100);
            4: press(3'b011);
            5: grant();
            default: respond(rnd128());
         endcase
         snapshot($sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/magma_entry_driver.md
# magma_entry_driver

Parametrised front-panel driver for the Magma board: user enters the plaintext/data block and the cipher key one hex nibble at a time with three buttons, views any page of data, key or result on the 7-segment bank, and launches the cipher core through a valid/ready request with result capture. It replaces the fixed 128-bit, 8-digit panel driver. It adds button debounce, cursor wrap, a request/response handshake to the core, and width and digit-count generics.

## Interface
Parameters:
- DATA_W, 128: data/key/result width in bits; multiple of 4*DIGITS.
- DIGITS, 8: 7-segment digits on the panel; one page = DIGITS nibbles.
- DB_CYCLES, 50000: consecutive stable cycles before a debounced button level changes.
- BLINK_W, 24: blink counter width; the MSB is the blink phase.
- AR_DELAY, 25000000 / AR_PERIOD, 5000000: autorepeat hold delay and repeat interval in cycles (used only with the macro).

Ports (PAGES = DATA_W/(4*DIGITS), PW = max(1,$clog2(PAGES))):
- clk, in, 1: clock; all state on rising edge.
- reset, in, 1: asynchronous, active-low; all registers cleared immediately.
- btn, in, 3: raw buttons, active-low (0 = pressed); [0] left, [1] right, [2] set.
- mode, in, 3: priority decode; [0] DATA edit, else [1] KEY edit, else [2] RESULT view, else IDLE view.
- page, in, PW: displayed page; values ≥ PAGES display blanks and block writes.
- nibble, in, 4: hex value written on set.
- page_led, out, PAGES: one-hot of page (all zero if out of range).
- mode_led, out, 3: [0] IDLE or DATA, [1] KEY, [2] RESULT.
- seg, out, 7*DIGITS: active-low segments; digit i in bits [7i+6:7i], bit order gfedcba.
- data_o / key_o, out, DATA_W: stored data and key.
- req_valid, out, 1 / req_ready, in, 1: launch request to the cipher core.
- res_valid, in, 1 / res_data, in, DATA_W: core result.
- busy, out, 1: request FSM not IDLE.

## Operation
- Button path: 2-flop synchroniser, then a per-button debounce counter. The debounced level changes after DB_CYCLES consecutive equal samples. A press event is a 1-cycle pulse on the debounced 1→0 transition.
- A cycle with more than one press event is dropped entirely.
- Cursor: 0..DIGITS-1, reset 0. Left increments (DIGITS-1 → 0); right decrements (0 → DIGITS-1). Cursor moves only in DATA/KEY edit modes and is kept across page and mode changes.
- Set in DATA/KEY edit: writes nibble into bits [4*(page*DIGITS+cursor)+3 : …] of the data or key register. The write is ignored while busy or when page is out of range.
- Set in IDLE view with FSM IDLE: starts a request. Set in RESULT view does nothing.
- FSM states:
  - IDLE: set-in-IDLE-view → REQ.
  - REQ: req_valid=1; on req_ready → WAIT.
  - WAIT: on res_valid, capture res_data into the result register → IDLE.
- res_valid outside WAIT is ignored. A result is captured even if the mode changed meanwhile.
- Display source:
  - DATA edit: data with the pending nibble substituted at the cursor (preview).
  - KEY edit: key with the same preview.
  - RESULT view: result register.
  - IDLE view: data.
- Digit i shows nibble page*DIGITS+i. Hex font 0-F, standard active-low.
- Blink: free-running BLINK_W counter. In edit modes, while MSB=0, the cursor digit is blanked (all 1s).
- Reset values: data, key, result, cursor, blink counter all 0; FSM IDLE; req_valid=0; busy=0; debounced levels released (1). seg then shows page 0 of zeros, "0" on every digit.

## Timing
- Press event 2+DB_CYCLES cycles after a stable raw press, plus up to one cycle.
- Register write and cursor move take effect on the clock edge after the event. seg is combinational from registers.
- req_valid asserts the cycle after the set event and holds until sampled with req_ready high. Valid/ready transfer occurs on that edge; no combinational path from req_ready to req_valid.
- Result visible on seg and registered one cycle after res_valid in WAIT. busy falls on the same edge.
- Reset mid-request drops req_valid asynchronously; a late res_valid is ignored.

## Configuration
- ENTRY_AUTOREPEAT_EN defined: in edit modes, left/right held (debounced low) alone for AR_DELAY cycles generate a move event, then one every AR_PERIOD while held. Release or any other button cancels the repeat.
- Undefined: one move per press; the autorepeat logic and parameters are unused.

## Test plan
Bench parameters: DATA_W=128, DIGITS=8, DB_CYCLES=4, BLINK_W=4.
- Reset low mid-run → data_o=key_o=0, req_valid=0, busy=0, all 8 digits show "0" (7'b1000000).
- Mode DATA, page 1, right once, nibble=A, set → cursor=7; data_o=128'hA<<60; digit 7 reads A when not blanked.
- Mode KEY, page 3, left ×9 → cursor wraps to 1; set with nibble=5 → key_o=128'h5<<100.
- Bounce: btn[2] toggles every 2 cycles for 20 cycles then holds low → exactly one write.
- Left and right pressed on the same cycle → cursor unchanged. Set while busy in DATA mode → data_o unchanged.
- IDLE set, req_ready held low 10 cycles then high → req_valid high 10+1 cycles. res_valid in REQ ignored; res_valid=1 with res_data=128'h0123…CDEF in WAIT → result captured, RESULT view page 0 shows "89ABCDEF" (digit 7 = 8), busy=0.
